pk_lamp_tx: RTL
===============

# pk_lamp_tx

Serializes the control-panel lamp state (W bus, P/MC indicators, status flags) into a fixed 7-byte frame and feeds it to the UART transmitter, so the host-side panel can mirror the lamps. It is the FPGA→host path of the P-K unit. It sits between the P-K unit's lamp signals and the `uart` TX side, and it services the `3'b110` "send lamps" host command. It can also push frames on its own when lamp state changes, rate-limited.

## Interface
Parameters:
- `GAP_CYCLES`, default 20'd500000: minimum idle clocks between the end of one frame and the start of the next (10 ms at 50 MHz).
- `AUTO`, default 1'b1: 1 = a lamp-state change schedules a frame; 0 = frames are sent only on `req`.

Ports (one clock; reset is asynchronous, active-low):
- `clk` in 1: system clock (`CLK_EXT` domain).
- `rst_` in 1: asynchronous active-low reset.
- `req` in 1: one-clock request strobe, from decode of a host byte with `rx_byte[7:5]==3'b110`.
- `w` in [0:15]: W bus as displayed; bit 0 is the MSB.
- `p_`, `mc_`, `alarm_`, `wait_` in 1 each: active-low lamp sources.
- `irq`, `q`, `run`, `mode`, `stop_n`, `zeg` in 1 each: active-high lamp sources.
- `tx_busy` in 1: UART transmitter busy.
- `tx_byte` out 8: byte presented to the UART; registered.
- `tx_send` out 1: one-clock strobe; the UART latches `tx_byte` on it.
- `busy` out 1: high from frame start to the last byte's drain.
- `frame_done` out 1: one-clock pulse after the last byte drains.

## Operation
- **Status word:** S[27:0] is packed combinationally as nibbles N0..N6:
  - N0 = `w[0:3]`, N1 = `w[4:7]`, N2 = `w[8:11]`, N3 = `w[12:15]`.
  - N4 = {`run`, ~`wait_`, ~`alarm_`, `irq`}.
  - N5 = {`mode`, `stop_n`, `zeg`, `q`}.
  - N6 = {~`p_`, ~`mc_`, 2'b00}.
- **Frame:** byte i (i = 0..6) = {1'b1, i[2:0], snap_Ni}. Bytes are always sent in order 0..6. The frame is taken from a snapshot `snap` latched in LOAD, so it stays consistent even if the inputs change mid-frame.
- **Pending flag:**
  - Set by `req`.
  - When `AUTO` = 1, also set when S differs from `last` (the snapshot of the most recently sent frame).
  - Cleared in LOAD.
  - A `req` or change arriving during a frame is kept pending; it is not lost and not duplicated.
- **Gap counter:** 20-bit down-counter. Loaded with `GAP_CYCLES` at `frame_done`, decrements to 0 and holds there. It is 0 after reset.
- **FSM states:**
  - IDLE: go to LOAD when pending && gap==0 && !`tx_busy`.
  - LOAD: `snap` <= S; `last` <= S; idx <= 0; go to SEND.
  - SEND: `tx_byte` <= frame byte idx; `tx_send` = 1 for this cycle only; go to ACK.
  - ACK: wait for `tx_busy`=1; go to DRAIN. If `tx_busy` is still 0 after 4 clocks, treat the byte as sent and go to DRAIN (lost-handshake guard).
  - DRAIN: wait for `tx_busy`=0. If idx==6, pulse `frame_done`, load gap, go to IDLE. Otherwise idx++ and go to SEND.
- **Reset values:** `tx_byte`=8'h00, `tx_send`=0, `busy`=0, `frame_done`=0, state=IDLE, pending=0, gap=0, idx=0, `snap`=0, `last`=0.
  - Since `last`=0 after reset, the first nonzero lamp state with `AUTO` = 1 produces a frame.
- **Asynchronous reset mid-frame:** aborts the frame immediately. `tx_send` drops and no partial-frame resume occurs.

## Timing
- `req` sampled high at edge n (idle, gap=0, `tx_busy`=0): LOAD at n+1, `tx_send` high with byte 0 during cycle n+2.
- Byte-to-byte spacing is set by the UART: the next `tx_send` comes 1 clock after `tx_busy` falls.
- `tx_send` is never asserted while `tx_busy`=1 or in two consecutive cycles.
- `req` and a change detected in the same cycle produce one pending frame.
- `frame_done` and a new `req` in the same cycle: the request is pending and starts after the gap expires.
- `busy` is high from LOAD through the DRAIN exit of byte 6 inclusive.
- Gap boundary: with `GAP_CYCLES`=G, the next LOAD occurs no earlier than G+1 clocks after `frame_done`.

## Test plan
- **Single request:** `AUTO`=0, `w`=16'hA5C3, `run`=1, `p_`=0, others inactive; pulse `req`; UART model busy for 10 clocks per byte → bytes 8'h8A, 8'h95, 8'hAC, 8'hB3, 8'hC8, 8'hD0, 8'hE8 in order, one `frame_done`.
- **Snapshot consistency:** change `w` to 16'hFFFF after byte 1 is sent → remaining bytes still carry 16'hA5C3 nibbles. With `AUTO`=1, a second frame with F nibbles follows after the gap.
- **Rate limit:** `GAP_CYCLES`=100, `AUTO`=1, toggle `q` every 5 clocks → each LOAD at least 101 clocks after the previous `frame_done`. No `tx_send` while `tx_busy`=1.
- **Lost handshake:** `tx_busy` tied 0 → each byte advances 4 clocks after ACK entry, and the frame completes with 7 `tx_send` strobes.
- **Reset mid-frame:** assert `rst_` low after byte 3 → all outputs go to reset values immediately. After release with unchanged lamps and `AUTO`=1, a full frame restarts at byte 0.
- **Collision:** `req` asserted on the `frame_done` cycle → exactly one additional frame, not two.

Source files
------------

// File: rtl/pk_lamp_tx.sv
// Lamp-state frame transmitter: packs the panel lamps into a 7-byte frame and
// hands it byte by byte to the UART TX side, on host request or on lamp change.
module pk_lamp_tx #(
  parameter logic [19:0] GAP_CYCLES = 20'd500000,
  parameter bit          AUTO       = 1'b1
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        req,
  input  logic [0:15] w,
  input  logic        p_,
  input  logic        mc_,
  input  logic        alarm_,
  input  logic        wait_,
  input  logic        irq,
  input  logic        q,
  input  logic        run,
  input  logic        mode,
  input  logic        stop_n,
  input  logic        zeg,
  input  logic        tx_busy,
  output logic [7:0]  tx_byte,
  output logic        tx_send,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_ACK,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic        pending_q, pending_d;
  logic [19:0] gap_q, gap_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  ack_cnt_q, ack_cnt_d;
  logic [27:0] snap_q, snap_d;
  logic [27:0] last_q, last_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_send_q, tx_send_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;

  // Nibble i of the status word lives at status[4*i +: 4] (N0 lowest).
  logic [27:0] status;
  logic        lamp_change;

  assign status = {~p_, ~mc_, 2'b00,
                   mode, stop_n, zeg, q,
                   run, ~wait_, ~alarm_, irq,
                   w[12:15], w[8:11], w[4:7], w[0:3]};

  assign lamp_change = AUTO && (status != last_q);

  function automatic logic [7:0] frame_byte(input logic [27:0] s, input logic [2:0] i);
    logic [3:0] nib;
    case (i)
      3'd0:    nib = s[3:0];
      3'd1:    nib = s[7:4];
      3'd2:    nib = s[11:8];
      3'd3:    nib = s[15:12];
      3'd4:    nib = s[19:16];
      3'd5:    nib = s[23:20];
      3'd6:    nib = s[27:24];
      default: nib = 4'h0;
    endcase
    return {1'b1, i, nib};
  endfunction

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    ack_cnt_d    = ack_cnt_q;
    snap_d       = snap_q;
    last_d       = last_q;
    tx_byte_d    = tx_byte_q;
    frame_done_d = 1'b0;
    pending_d    = pending_q | req | lamp_change;
    gap_d        = (gap_q != 20'd0) ? gap_q - 20'd1 : 20'd0;

    case (state_q)
      S_IDLE: begin
        if (pending_q && (gap_q == 20'd0) && !tx_busy) state_d = S_LOAD;
      end
      S_LOAD: begin
        snap_d    = status;
        last_d    = status;
        idx_d     = 3'd0;
        // The change that triggered this frame is being served now; only a
        // request arriving in this very cycle stays pending.
        pending_d = req;
        tx_byte_d = frame_byte(status, 3'd0);
        state_d   = S_SEND;
      end
      S_SEND: begin
        ack_cnt_d = 2'd0;
        state_d   = S_ACK;
      end
      S_ACK: begin
        // Give the UART four clocks to raise busy before assuming it took the byte.
        if (tx_busy || (ack_cnt_q == 2'd3)) state_d = S_DRAIN;
        else                                 ack_cnt_d = ack_cnt_q + 2'd1;
      end
      S_DRAIN: begin
        if (!tx_busy) begin
          if (idx_q == 3'd6) begin
            frame_done_d = 1'b1;
            gap_d        = GAP_CYCLES;
            state_d      = S_IDLE;
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_byte_d = frame_byte(snap_q, idx_q + 3'd1);
            state_d   = S_SEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    tx_send_d = (state_d == S_SEND);
    busy_d    = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= S_IDLE;
      pending_q    <= 1'b0;
      gap_q        <= 20'd0;
      idx_q        <= 3'd0;
      ack_cnt_q    <= 2'd0;
      snap_q       <= 28'd0;
      last_q       <= 28'd0;
      tx_byte_q    <= 8'h00;
      tx_send_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      gap_q        <= gap_d;
      idx_q        <= idx_d;
      ack_cnt_q    <= ack_cnt_d;
      snap_q       <= snap_d;
      last_q       <= last_d;
      tx_byte_q    <= tx_byte_d;
      tx_send_q    <= tx_send_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_byte    = tx_byte_q;
  assign tx_send    = tx_send_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
